// File: rtl/bus_rx_pkg.sv
// Shared types and default constants for the bus receive endpoint.
package bus_rx_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TURN  = 1;
  localparam int BLEN_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_TURN    = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only
// when a pop happens on the same edge.
module sync_fifo
  import bus_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Head is forced to zero while empty so the port reads 0 out of reset.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_rx_port.sv
// Receive endpoint of the shared tri-state data bus: burst tracking,
// turnaround enforcement, FIFO buffering and driver back-pressure.
//
// state     | meaning
// S_IDLE    | bus quiet, a sampled bus_en starts a burst
// S_CAPTURE | burst in progress, every bus_en edge is a push
// S_TURN    | turnaround gap, bus_en here is a protocol error
module bus_rx_port
  import bus_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TURN  = DEF_TURN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  bus,
  input  logic              bus_en,
  output logic              bus_hold,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [BLEN_W-1:0] burst_len,
  output logic              burst_done,
  output logic              overflow,
  output logic              proto_err,
  input  logic              clr_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;
  localparam logic [TW-1:0] TURN_LOAD = TW'((TURN > 0) ? TURN - 1 : 0);
  localparam logic [BLEN_W-1:0] BLEN_MAX = '1;

  state_t            r_state;
  logic [TW-1:0]     r_turn_cnt;
  logic [BLEN_W-1:0] r_word_cnt;
  logic [BLEN_W-1:0] r_burst_len;
  logic              r_burst_done;
  logic              r_overflow;
  logic              r_proto_err;
  logic              r_hold;

  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_cnt_next;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_pop;

  assign w_push_req = bus_en & (r_state != S_TURN);
  assign w_pop      = ~w_empty & rd_ready;
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_cnt_next = w_count + CW'(w_push_ok) - CW'(w_pop);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_ok),
    .i_pop   (w_pop),
    .i_wdata (bus),
    .o_rdata (rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Burst FSM with word counter, burst length latch and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_turn_cnt   <= '0;
      r_word_cnt   <= '0;
      r_burst_len  <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus_en) begin
            r_state    <= S_CAPTURE;
            r_word_cnt <= w_push_ok ? BLEN_W'(1) : '0;
          end
        end
        S_CAPTURE: begin
          if (bus_en) begin
            if (w_push_ok && r_word_cnt != BLEN_MAX) r_word_cnt <= r_word_cnt + BLEN_W'(1);
          end else begin
            r_burst_len  <= r_word_cnt;
            r_burst_done <= 1'b1;
            if (TURN == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_state    <= S_TURN;
              r_turn_cnt <= TURN_LOAD;
            end
          end
        end
        S_TURN: begin
          if (r_turn_cnt == '0) r_state <= S_IDLE;
          else                  r_turn_cnt <= r_turn_cnt - TW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags (clear wins) and registered hold with one word of slack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
      r_hold      <= 1'b0;
    end else begin
      r_hold <= (w_cnt_next >= CW'(DEPTH - 1));
      if (clr_err) begin
        r_overflow  <= 1'b0;
        r_proto_err <= 1'b0;
      end else begin
        if (w_push_req && !w_push_ok)        r_overflow  <= 1'b1;
        if (r_state == S_TURN && bus_en)     r_proto_err <= 1'b1;
      end
    end
  end

  assign rd_valid   = ~w_empty;
  assign bus_hold   = r_hold;
  assign burst_len  = r_burst_len;
  assign burst_done = r_burst_done;
  assign overflow   = r_overflow;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_bus_rx_port.sv
// Scoreboard bench for bus_rx_port with default parameters (8/4/1).
module tb_bus_rx_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus = '0;
  logic       bus_en = 1'b0;
  logic       bus_hold;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [3:0] burst_len;
  logic       burst_done;
  logic       overflow;
  logic       proto_err;
  logic       clr_err = 1'b0;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         done_snap;
  logic [7:0] exp_q [$];
  logic [7:0] m_exp;

  bus_rx_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .bus_en     (bus_en),
    .bus_hold   (bus_hold),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .burst_len  (burst_len),
    .burst_done (burst_done),
    .overflow   (overflow),
    .proto_err  (proto_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit expect_q);
    bus_en = 1'b1;
    bus    = d;
    if (expect_q) exp_q.push_back(d);
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  // Monitor: every accepted pop is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rd_valid === 1'b1 && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", rd_data);
      end else begin
        m_exp = exp_q.pop_front();
        if (rd_data !== m_exp) begin
          errors++;
          $display("FAIL pop_data actual=%0h required=%0h", rd_data, m_exp);
        end
      end
    end
    if (rst_n && burst_done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs
    repeat (3) begin
      bus      = 8'($urandom);
      bus_en   = 1'($urandom);
      rd_ready = 1'($urandom);
      clr_err  = 1'($urandom);
      tick();
    end
    check("rst_outputs", {rd_valid, bus_hold, burst_done, overflow, proto_err, burst_len, rd_data}, '0);
    bus = '0; bus_en = 1'b0; rd_ready = 1'b0; clr_err = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_outputs", {rd_valid, bus_hold, burst_done, overflow, proto_err, burst_len, rd_data}, '0);
    check("post_rst_state", 32'(dut.r_state), 32'(bus_rx_pkg::S_IDLE));

    // Three-word burst, then drain
    send(8'hA5, 1'b1); tick();
    check("latency_valid", rd_valid, 1);
    check("latency_data", rd_data, 8'hA5);
    send(8'h3C, 1'b1); tick();
    send(8'hFF, 1'b1); tick();
    check("burst_hold3", bus_hold, 1);
    bus_en = 1'b0; tick();
    check("burst_done", burst_done, 1);
    check("burst_len3", burst_len, 3);
    tick();
    check("burst_done_once", burst_done, 0);
    drain(3);
    check("burst_empty", rd_valid, 0);
    check("burst_hold_clr", bus_hold, 0);
    check("burst_done_cnt", done_cnt, 1);

    // Fill: six words into a four-entry FIFO
    send(8'h11, 1'b1); tick();
    send(8'h22, 1'b1); tick();
    check("fill_hold2", bus_hold, 0);
    send(8'h33, 1'b1); tick();
    check("fill_hold3", bus_hold, 1);
    send(8'h44, 1'b1); tick();
    check("fill_no_ovf4", overflow, 0);
    send(8'h55, 1'b0); tick();
    check("fill_ovf5", overflow, 1);
    send(8'h66, 1'b0); tick();
    bus_en = 1'b0; tick();
    check("fill_burst_len", burst_len, 4);
    check("fill_overflow", overflow, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("fill_clr", overflow, 0);

    // Full FIFO with simultaneous push and pop
    send(8'h77, 1'b1); rd_ready = 1'b1; tick();
    bus_en = 1'b0; rd_ready = 1'b0;
    check("simul_count", 32'(dut.w_count), 4);
    check("simul_no_ovf", overflow, 0);
    check("simul_head", rd_data, 8'h22);
    tick();
    check("simul_burst_len", burst_len, 1);
    drain(4);
    check("simul_empty", rd_valid, 0);

    // Turnaround violation then a legal burst
    send(8'h5A, 1'b1); tick();
    bus_en = 1'b0; tick();
    send(8'hEE, 1'b0); tick();
    check("turn_proto_err", proto_err, 1);
    check("turn_not_queued", 32'(dut.w_count), 1);
    bus_en = 1'b0; tick();
    send(8'h6B, 1'b1); tick();
    bus_en = 1'b0; tick();
    check("turn_burst_len", burst_len, 1);
    check("turn_count", 32'(dut.w_count), 2);
    drain(2);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("turn_clr", proto_err, 0);

    // Reset in the middle of a burst
    done_snap = done_cnt;
    send(8'h01, 1'b1); tick();
    send(8'h02, 1'b1); tick();
    check("mid_count", 32'(dut.w_count), 2);
    rst_n = 1'b0; bus_en = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", rd_valid, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("mid_no_done", done_cnt, done_snap);
    check("mid_empty", rd_valid, 0);
    check("mid_burst_len", burst_len, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
